// File: rtl/i2c_slave_responder.sv
// I2C slave responder: address match, pointer-addressed byte register file,
// write/read transfers with ACK handling, no clock stretching.
module i2c_slave_responder #(
  parameter int unsigned                I2C_ADDR_WIDTH = 7,
  parameter int unsigned                I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0]  SLAVE_ADDR     = 7'h22,
  parameter int unsigned                MEM_DEPTH      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          scl_i,
  input  logic                          sda_i,
  output logic                          sda_o,
  output logic                          busy_o,
  output logic                          rx_valid_o,
  output logic [I2C_DATA_WIDTH-1:0]     rx_data_o,
  output logic [$clog2(MEM_DEPTH)-1:0]  rx_ptr_o
);

  localparam int unsigned DW = I2C_DATA_WIDTH;
  localparam int unsigned PW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = $clog2(I2C_DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
  localparam logic [CW-1:0] ALL_BITS = CW'(DW);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  logic          r_scl_s1, r_scl_s2, r_scl_d;
  logic          r_sda_s1, r_sda_s2, r_sda_d;
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [DW-1:0] r_shift, w_shift_n;
  logic          r_rw, w_rw_n;
  logic          r_first, w_first_n;
  logic [PW-1:0] r_ptr, w_ptr_n;
  logic          r_sda_o, w_sda_n;
  logic          r_busy, w_busy_n;
  logic          r_rx_valid, w_rx_valid_n;
  logic [DW-1:0] r_rx_data, w_rx_data_n;
  logic [PW-1:0] r_rx_ptr, w_rx_ptr_n;
  logic          w_mem_we;
  logic [DW-1:0] r_mem [MEM_DEPTH];

  logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_match;
  logic [DW-1:0] w_byte;

  // Two-flop synchronizers plus one-cycle-delayed copies for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda_i; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift[DW-2:0], r_sda_s2};
  assign w_match    = (r_shift[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state and next-output logic; bus conditions override bit timing
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_shift_n    = r_shift;
    w_rw_n       = r_rw;
    w_first_n    = r_first;
    w_ptr_n      = r_ptr;
    w_sda_n      = r_sda_o;
    w_busy_n     = r_busy;
    w_rx_valid_n = 1'b0;
    w_rx_data_n  = r_rx_data;
    w_rx_ptr_n   = r_rx_ptr;
    w_mem_we     = 1'b0;
    if (w_stop) begin
      w_state_n = S_IDLE;
      w_sda_n   = 1'b1;
      w_busy_n  = 1'b0;
    end else if (w_start) begin
      w_state_n = S_ADDR;
      w_cnt_n   = '0;
      w_sda_n   = 1'b1;
      w_busy_n  = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_scl_rise && r_cnt != ALL_BITS) begin
            w_shift_n = w_byte;
            w_cnt_n   = r_cnt + CW'(1);
          end else if (w_scl_fall && r_cnt == ALL_BITS) begin
            if (w_match) begin
              w_state_n = S_ADDR_ACK;
              w_sda_n   = 1'b0;
              w_busy_n  = 1'b1;
              w_rw_n    = r_shift[0];
            end else begin
              w_state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_n = '0;
            if (r_rw) begin
              w_state_n = S_RD_BYTE;
              w_shift_n = r_mem[r_ptr];
              w_sda_n   = r_mem[r_ptr][DW-1];
            end else begin
              w_state_n = S_WR_BYTE;
              w_sda_n   = 1'b1;
              w_first_n = 1'b1;
            end
          end
        end
        S_WR_BYTE: begin
          if (w_scl_rise && r_cnt != ALL_BITS) begin
            w_shift_n = w_byte;
            w_cnt_n   = r_cnt + CW'(1);
            if (r_cnt == LAST_BIT) begin
              if (r_first) begin
                w_ptr_n   = w_byte[PW-1:0];
                w_first_n = 1'b0;
              end else begin
                w_mem_we     = 1'b1;
                w_rx_valid_n = 1'b1;
                w_rx_data_n  = w_byte;
                w_rx_ptr_n   = r_ptr;
                w_ptr_n      = r_ptr + PW'(1);
              end
            end
          end else if (w_scl_fall && r_cnt == ALL_BITS) begin
            w_state_n = S_WR_ACK;
            w_sda_n   = 1'b0;
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            w_state_n = S_WR_BYTE;
            w_sda_n   = 1'b1;
            w_cnt_n   = '0;
          end
        end
        S_RD_BYTE: begin
          if (w_scl_rise && r_cnt != ALL_BITS) begin
            w_cnt_n = r_cnt + CW'(1);
          end else if (w_scl_fall && r_cnt != '0) begin
            if (r_cnt == ALL_BITS) begin
              w_state_n = S_RD_ACK;
              w_sda_n   = 1'b1;
            end else begin
              w_shift_n = {r_shift[DW-2:0], 1'b0};
              w_sda_n   = r_shift[DW-2];
            end
          end
        end
        S_RD_ACK: begin
          // cnt cleared on an ACKed 9th rise marks "next fall starts a byte"
          if (w_scl_rise) begin
            if (r_sda_s2) begin
              w_state_n = S_IGNORE;
              w_busy_n  = 1'b0;
            end else begin
              w_ptr_n = r_ptr + PW'(1);
              w_cnt_n = '0;
            end
          end else if (w_scl_fall && r_cnt == '0) begin
            w_state_n = S_RD_BYTE;
            w_shift_n = r_mem[r_ptr];
            w_sda_n   = r_mem[r_ptr][DW-1];
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_first    <= 1'b0;
      r_ptr      <= '0;
      r_sda_o    <= 1'b1;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_ptr   <= '0;
    end else begin
      r_cnt      <= w_cnt_n;
      r_shift    <= w_shift_n;
      r_rw       <= w_rw_n;
      r_first    <= w_first_n;
      r_ptr      <= w_ptr_n;
      r_sda_o    <= w_sda_n;
      r_busy     <= w_busy_n;
      r_rx_valid <= w_rx_valid_n;
      r_rx_data  <= w_rx_data_n;
      r_rx_ptr   <= w_rx_ptr_n;
    end
  end

  // Byte register file, cleared by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

  assign sda_o      = r_sda_o;
  assign busy_o     = r_busy;
  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
  assign rx_ptr_o   = r_rx_ptr;

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 Parameter I2C_ADDR_WIDTH, default 7, width of the I2C device address.
REQ-002 Parameter I2C_DATA_WIDTH, default 8, width of a data byte.
REQ-003 Parameter SLAVE_ADDR, default 7'h22, address this responder answers to.
REQ-004 Parameter MEM_DEPTH, default 16, number of byte registers (power of two).
REQ-005 Port clk_i  in  1  system clock; single clock domain, all logic on rising edge.
REQ-006 Port rst_i  in  1  reset, asynchronous, active-high.
REQ-007 Port scl_i  in  1  I2C clock, bus level (asynchronous to clk_i).
REQ-008 Port sda_i  in  1  I2C data, bus level (asynchronous to clk_i).
REQ-009 Port sda_o  out  1  open-drain data drive: 0 = pull low, 1 = release.
REQ-010 Port busy_o  out  1  high from address match until STOP, repeated START, or master NACK.
REQ-011 Port rx_valid_o  out  1  one-cycle pulse per accepted written data byte.
REQ-012 Port rx_data_o  out  I2C_DATA_WIDTH  byte accepted; valid with rx_valid_o.
REQ-013 Port rx_ptr_o  out  log2(MEM_DEPTH)  register index written; valid with rx_valid_o.

Function
REQ-014 scl_i and sda_i SHALL pass a 2-FF synchronizer; all detection uses the synchronized values plus a one-cycle-delayed copy.
REQ-015 START = synchronized sda falling while scl high; STOP = sda rising while scl high; each detected in exactly one clk_i cycle.
REQ-016 Data bits SHALL be sampled on synchronized scl rising edges, MSB first.
REQ-017 sda_o SHALL change only in the cycle after a synchronized scl falling edge.
REQ-018 FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-019 IDLE -> ADDR on START; bits 7..1 are the address, bit 0 is R/W (1 = read).
REQ-020 On address match: ADDR -> ADDR_ACK; sda_o = 0 from the scl fall after bit 8 until the scl fall after bit 9; busy_o = 1.
REQ-021 On address mismatch: ADDR -> IGNORE; sda_o stays 1 and busy_o stays 0.
REQ-022 After ADDR_ACK: R/W = 0 -> WR_BYTE; R/W = 1 -> RD_BYTE.
REQ-023 The first written byte after an address phase SHALL load the pointer (low log2(MEM_DEPTH) bits), is ACKed, and does not pulse rx_valid_o.
REQ-024 Each subsequent written byte SHALL be stored at mem[ptr], ACKed (WR_ACK), pulse rx_valid_o with rx_data_o/rx_ptr_o in the cycle after the 8th bit's scl rise, then increment ptr.
REQ-025 RD_BYTE SHALL drive mem[ptr] MSB first, beginning on the scl fall that ends the ACK slot; it releases sda_o on the scl fall after bit 8.
REQ-026 RD_ACK SHALL sample master ACK on the 9th scl rise: ACK (0) -> increment ptr and go to RD_BYTE; NACK (1) -> IGNORE with busy_o = 0.
REQ-027 The pointer SHALL wrap from MEM_DEPTH-1 to 0 on both reads and writes.
REQ-028 A START in any non-IDLE state (repeated START) SHALL release sda_o and go to ADDR; the pointer is retained.
REQ-029 A STOP in any state SHALL go to IDLE, release sda_o, and clear busy_o.
REQ-030 If START/STOP and a scl edge fall in the same cycle, START/STOP SHALL take priority.
REQ-031 IGNORE SHALL leave only on START or STOP.
REQ-032 The responder SHALL never drive scl (no clock stretching); general-call address 0 is not acknowledged unless SLAVE_ADDR = 0.

Reset
REQ-033 While rst_i is high: state = IDLE, sda_o = 1, busy_o = 0, rx_valid_o = 0, rx_data_o = 0, rx_ptr_o = 0, ptr = 0, synchronizer FFs = 1, all mem entries = 0.
REQ-034 Assertion of rst_i mid-transfer SHALL release sda_o immediately; after deassertion, the responder waits for a fresh START.

Verification
REQ-035 Write 0x44, 0x03, 0xA5, 0x5A, STOP -> ACK on all bytes; rx_valid_o pulses twice: (0xA5, ptr 3), then (0x5A, ptr 4).
REQ-036 After REQ-035: write 0x44, 0x03, repeated START, 0x45, read 2 bytes with ACK then NACK, STOP -> returns 0xA5, 0x5A; busy_o = 0 after the NACK.
REQ-037 Address 0x46 (0x23 write) followed by 3 bytes -> sda_o never 0; rx_valid_o never pulses; busy_o stays 0.
REQ-038 Write 0x44, 0x0F, 0x11, 0x22 -> rx_ptr_o = 15 then 0; a read from pointer 15 returns 0x11, 0x22.
REQ-039 STOP injected after bit 4 of a data byte -> IDLE next cycle, sda_o = 1, no rx_valid_o, mem unchanged.
REQ-040 rst_i asserted while the responder is driving an ACK -> sda_o = 1 within the same cycle; the next valid transfer completes normally.
